trap_profile_gen: RTL and testbench
===================================

TRAP_PROFILE_GEN -- requirements
Module: trap_profile_gen

Interface
REQ-001 Parameter: DIV, default 10, system clocks per profile tick (DIV >= 2).
REQ-002 Parameter: W, default 16, output sample width.
REQ-003 Parameter: CNT_W, default 10, width of the segment-length inputs.
REQ-004 Port: clk  in  1  system clock; all logic SHALL run on its rising edge. No derived clocks.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: enable  in  1  level; high allows profile generation.
REQ-007 Port: start  in  1  single-clk pulse; starts a profile from IDLE.
REQ-008 Port: oneshot  in  1  1 = stop after one period; 0 = repeat continuously.
REQ-009 Port: cfg_rise_len, cfg_hold_len, cfg_fall_len, cfg_low_len  in  CNT_W each  segment lengths in ticks.
REQ-010 Port: cfg_step  in  W  amplitude increment/decrement per tick.
REQ-011 Port: expect_signal  out  W  unsigned profile sample.
REQ-012 Port: phase  out  3  current state encoding: IDLE=0, RISE=1, HOLD=2, FALL=3, LOW=4.
REQ-013 Port: busy  out  1  high in any state other than IDLE.
REQ-014 Port: period_done  out  1  single-clk pulse at the end of each complete period.

Function
REQ-015 Tick: internal divider SHALL assert a one-clk tick every DIV clks while busy. Divider SHALL be cleared to 0 on entry to RISE from IDLE, so the first tick occurs DIV clks after entry.
REQ-016 All state changes and expect_signal updates SHALL occur only on tick clks, except the IDLE/abort rules below.
REQ-017 IDLE -> RISE on the clk after start=1 with enable=1. start is ignored while busy.
REQ-018 On entry to RISE (from IDLE or LOW), all cfg_* inputs SHALL be latched. Changes mid-period SHALL take effect at the next period.
REQ-019 Segment counter SHALL count ticks within the current segment. After exactly len ticks the state advances: RISE -> HOLD -> FALL -> LOW -> (RISE if oneshot=0, else IDLE).
REQ-020 A segment of length 0 SHALL be skipped in the same tick that would have entered it. A period with all lengths 0 SHALL return to IDLE (or restart) without changing the output.
REQ-021 RISE: each tick, expect_signal += step. The sum SHALL saturate at 2^W-1.
REQ-022 HOLD: expect_signal holds its value.
REQ-023 FALL: each tick, expect_signal -= step. The result SHALL saturate at 0.
REQ-024 LOW: expect_signal SHALL be 0 from its first tick.
REQ-025 period_done SHALL pulse on the tick that ends LOW (or the tick that ends the final non-empty segment when later segments are skipped). oneshot is sampled at that tick.
REQ-026 enable=0 while busy SHALL abort: the next clk forces IDLE, expect_signal=0, divider=0, and no period_done.
REQ-027 In IDLE, expect_signal SHALL be 0.

Reset
REQ-028 While rst_n=0: state=IDLE, expect_signal=0, busy=0, period_done=0, divider=0, segment counter=0, latched cfg=0, phase=0.
REQ-029 Release of rst_n SHALL NOT start a profile; an explicit start is required.
REQ-030 Reset asserted mid-period SHALL take effect immediately (asynchronously), with no partial period_done.

Verification
REQ-031 Defaults, cfg 20/20/20/20, step=1, oneshot=1, start pulse -> output ramps 1..20 over 20 ticks (200 clks), holds 20 for 200 clks, falls to 0, stays low 200 clks; period_done at clk 800 after entry to RISE; then IDLE.
REQ-032 Same cfg, oneshot=0 -> period_done every 800 clks and a seamless restart of RISE. cfg_step changed to 2 mid-period -> peak becomes 40 only in the next period.
REQ-033 W=8, rise=10, step=30 -> output saturates at 255 and holds 255. fall=3 -> output steps 225, 195, 165, then 0 in LOW.
REQ-034 hold=0, low=0 -> triangle profile: RISE goes directly to FALL; FALL ends the period with period_done; no zero-valued LOW tick.
REQ-035 enable dropped at tick 5 of HOLD -> IDLE and output 0 on the next clk, no period_done. rst_n pulsed during FALL -> all outputs return to reset values immediately, and the block waits for start.

Source files
------------

// File: rtl/trap_profile_gen.sv
// Trapezoidal expected-signal generator: rise / hold / fall / low segments
// stepped on a divided tick, with one-shot or continuous repetition.
//   state | meaning
//   IDLE  | waiting for start, output 0
//   RISE  | output += step per tick, saturating high
//   HOLD  | output held
//   FALL  | output -= step per tick, saturating at 0
//   LOW   | output forced to 0
module trap_profile_gen #(
    parameter int DIV   = 10,
    parameter int W     = 16,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             start,
    input  logic             oneshot,
    input  logic [CNT_W-1:0] cfg_rise_len,
    input  logic [CNT_W-1:0] cfg_hold_len,
    input  logic [CNT_W-1:0] cfg_fall_len,
    input  logic [CNT_W-1:0] cfg_low_len,
    input  logic [W-1:0]     cfg_step,
    output logic [W-1:0]     expect_signal,
    output logic [2:0]       phase,
    output logic             busy,
    output logic             period_done
);

    localparam int DIV_W = $clog2(DIV);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RISE = 3'd1,
        ST_HOLD = 3'd2,
        ST_FALL = 3'd3,
        ST_LOW  = 3'd4
    } state_t;

    state_t             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [CNT_W-1:0]   seg_q;
    logic [CNT_W-1:0]   rise_q, hold_q, fall_q, low_q;
    logic [W-1:0]       step_q;
    logic [W-1:0]       sig_q;
    logic               done_q;

    state_t             eff_st, adv_st;
    logic [CNT_W-1:0]   eff_seg, seg_inc;
    logic [W:0]         sum;
    logic [W-1:0]       sig_d;
    logic               tick, seg_end, period_end, load_cfg;

    // First non-empty segment after s; IDLE means the period is over.
    function automatic state_t next_seg(input state_t s, input logic [CNT_W-1:0] h,
                                        input logic [CNT_W-1:0] f, input logic [CNT_W-1:0] l);
        next_seg = ST_IDLE;
        case (s)
            ST_RISE: begin
                if (h != '0)      next_seg = ST_HOLD;
                else if (f != '0) next_seg = ST_FALL;
                else if (l != '0) next_seg = ST_LOW;
            end
            ST_HOLD: begin
                if (f != '0)      next_seg = ST_FALL;
                else if (l != '0) next_seg = ST_LOW;
            end
            ST_FALL: begin
                if (l != '0)      next_seg = ST_LOW;
            end
            default: next_seg = ST_IDLE;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] seg_len(input state_t s,
                                                 input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] h,
                                                 input logic [CNT_W-1:0] f, input logic [CNT_W-1:0] l);
        case (s)
            ST_RISE: seg_len = r;
            ST_HOLD: seg_len = h;
            ST_FALL: seg_len = f;
            ST_LOW:  seg_len = l;
            default: seg_len = '0;
        endcase
    endfunction

    assign tick = (state_q != ST_IDLE) && (div_q == DIV_W'(DIV - 1));

    // An empty RISE can only be current right after entry; the tick then acts
    // as the first tick of the next non-empty segment.
    always_comb begin
        eff_st  = state_q;
        eff_seg = seg_q;
        if (state_q == ST_RISE && rise_q == '0) begin
            eff_st  = next_seg(ST_RISE, hold_q, fall_q, low_q);
            eff_seg = '0;
        end
        sum   = {1'b0, sig_q} + {1'b0, step_q};
        sig_d = sig_q;
        case (eff_st)
            ST_RISE: sig_d = sum[W] ? '1 : sum[W-1:0];
            ST_FALL: sig_d = (sig_q > step_q) ? (sig_q - step_q) : '0;
            ST_LOW:  sig_d = '0;
            default: sig_d = sig_q;
        endcase
        seg_inc    = eff_seg + 1'b1;
        seg_end    = (seg_inc == seg_len(eff_st, rise_q, hold_q, fall_q, low_q));
        adv_st     = seg_end ? next_seg(eff_st, hold_q, fall_q, low_q) : eff_st;
        period_end = (eff_st == ST_IDLE) || (seg_end && adv_st == ST_IDLE);
    end

    assign load_cfg = ((state_q == ST_IDLE) && start && enable) ||
                      ((state_q != ST_IDLE) && enable && tick && period_end && !oneshot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= '0;
            hold_q <= '0;
            fall_q <= '0;
            low_q  <= '0;
            step_q <= '0;
        end else if (load_cfg) begin
            rise_q <= cfg_rise_len;
            hold_q <= cfg_hold_len;
            fall_q <= cfg_fall_len;
            low_q  <= cfg_low_len;
            step_q <= cfg_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            seg_q   <= '0;
            sig_q   <= '0;
            done_q  <= 1'b0;
        end else if (state_q == ST_IDLE || !enable) begin
            div_q  <= '0;
            seg_q  <= '0;
            sig_q  <= '0;
            done_q <= 1'b0;
            if (state_q == ST_IDLE && start && enable) state_q <= ST_RISE;
            else                                       state_q <= ST_IDLE;
        end else begin
            done_q <= 1'b0;
            div_q  <= tick ? '0 : div_q + 1'b1;
            if (tick) begin
                sig_q  <= sig_d;
                done_q <= period_end;
                if (period_end) begin
                    seg_q <= '0;
                    if (oneshot) begin
                        state_q <= ST_IDLE;
                        sig_q   <= '0;
                    end else begin
                        state_q <= ST_RISE;
                    end
                end else if (seg_end) begin
                    state_q <= adv_st;
                    seg_q   <= '0;
                end else begin
                    state_q <= eff_st;
                    seg_q   <= seg_inc;
                end
            end
        end
    end

    assign expect_signal = sig_q;
    assign phase         = state_q;
    assign busy          = (state_q != ST_IDLE);
    assign period_done   = done_q;

endmodule

// File: tb/tb_trap_profile_gen.sv
// Scoreboard bench for trap_profile_gen: a default instance and a narrow
// W=8/DIV=4 instance, with per-tick expected samples queued from the segment list.
module tb_trap_profile_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        en_a, start_a, os_a;
    logic [9:0]  r_a, h_a, f_a, l_a;
    logic [15:0] step_a, sig_a;
    logic [2:0]  ph_a;
    logic        busy_a, done_a;

    logic        en_b, start_b, os_b;
    logic [9:0]  r_b, h_b, f_b, l_b;
    logic [7:0]  step_b, sig_b;
    logic [2:0]  ph_b;
    logic        busy_b, done_b;

    trap_profile_gen dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .start(start_a), .oneshot(os_a),
        .cfg_rise_len(r_a), .cfg_hold_len(h_a), .cfg_fall_len(f_a), .cfg_low_len(l_a),
        .cfg_step(step_a), .expect_signal(sig_a), .phase(ph_a), .busy(busy_a),
        .period_done(done_a)
    );

    trap_profile_gen #(.DIV(4), .W(8), .CNT_W(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .start(start_b), .oneshot(os_b),
        .cfg_rise_len(r_b), .cfg_hold_len(h_b), .cfg_fall_len(f_b), .cfg_low_len(l_b),
        .cfg_step(step_b), .expect_signal(sig_b), .phase(ph_b), .busy(busy_b),
        .period_done(done_b)
    );

    typedef struct {
        int sig;
        int ph;
        int done;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    endtask

    // Expected post-tick sample/phase/done for one period, walking the non-empty segments.
    task automatic push_period(input int r, input int h, input int f, input int l,
                               input int step, input int maxv, input int os);
        int   lens[4];
        int   last;
        int   v;
        int   nx;
        exp_t e;
        lens = '{r, h, f, l};
        last = -1;
        v    = 0;
        for (int i = 0; i < 4; i++) if (lens[i] != 0) last = i;
        if (last < 0) begin
            e.sig = 0; e.ph = os ? 0 : 1; e.done = 1;
            sb.push_back(e);
            return;
        end
        for (int s = 0; s < 4; s++) begin
            for (int k = 1; k <= lens[s]; k++) begin
                case (s)
                    0: v = (v + step > maxv) ? maxv : v + step;
                    2: v = (v > step) ? v - step : 0;
                    3: v = 0;
                    default: v = v;
                endcase
                e.sig = v; e.done = 0; e.ph = s + 1;
                if (k == lens[s]) begin
                    if (s == last) begin
                        e.done = 1;
                        e.ph   = os ? 0 : 1;
                        if (os != 0) e.sig = 0;
                    end else begin
                        nx = s + 1;
                        while (lens[nx] == 0) nx++;
                        e.ph = nx + 1;
                    end
                end
                sb.push_back(e);
            end
        end
    endtask

    task automatic run_ticks(input int sel, input int n);
        exp_t  e;
        int    dv;
        string p;
        dv = (sel != 0) ? 4 : 10;
        p  = (sel != 0) ? "b" : "a";
        for (int i = 0; i < n; i++) begin
            repeat (dv) @(posedge clk);
            #1;
            chk("sb_nonempty", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk($sformatf("%s_sig_t%0d", p, i),  (sel != 0) ? int'(sig_b)  : int'(sig_a),  e.sig);
                chk($sformatf("%s_ph_t%0d", p, i),   (sel != 0) ? int'(ph_b)   : int'(ph_a),   e.ph);
                chk($sformatf("%s_busy_t%0d", p, i), (sel != 0) ? int'(busy_b) : int'(busy_a), int'(e.ph != 0));
                chk($sformatf("%s_done_t%0d", p, i), (sel != 0) ? int'(done_b) : int'(done_a), e.done);
            end
        end
    endtask

    task automatic start_pulse(input int sel);
        @(negedge clk);
        if (sel != 0) start_b = 1'b1;
        else          start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic set_a(input int r, input int h, input int f, input int l, input int step, input int os);
        r_a = 10'(r); h_a = 10'(h); f_a = 10'(f); l_a = 10'(l);
        step_a = 16'(step); os_a = 1'(os);
    endtask

    initial begin
        rst_n = 1'b0;
        en_a = 1'b1; start_a = 1'b0; en_b = 1'b1; start_b = 1'b0;
        set_a(0, 0, 0, 0, 0, 1);
        r_b = '0; h_b = '0; f_b = '0; l_b = '0; step_b = '0; os_b = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_sig", int'(sig_a), 0);
        chk("rst_a_ph", int'(ph_a), 0);
        chk("rst_a_busy", int'(busy_a), 0);
        chk("rst_a_done", int'(done_a), 0);
        chk("rst_b_sig", int'(sig_b), 0);
        chk("rst_b_busy", int'(busy_b), 0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("no_autostart_busy", int'(busy_a), 0);
        chk("no_autostart_sig", int'(sig_a), 0);

        // Basic one-shot trapezoid
        set_a(20, 20, 20, 20, 1, 1);
        push_period(20, 20, 20, 20, 1, 65535, 1);
        start_pulse(0);
        run_ticks(0, 80);
        @(posedge clk);
        #1;
        chk("oneshot_done_width", int'(done_a), 0);
        chk("oneshot_idle", int'(busy_a), 0);
        chk("sb_drained_1", sb.size(), 0);

        // Continuous mode; step change mid-period applies from the next period
        set_a(20, 20, 20, 20, 1, 0);
        push_period(20, 20, 20, 20, 1, 65535, 0);
        push_period(20, 20, 20, 20, 2, 65535, 1);
        start_pulse(0);
        run_ticks(0, 30);
        step_a = 16'd2;
        run_ticks(0, 50);
        os_a = 1'b1;
        run_ticks(0, 80);
        chk("sb_drained_2", sb.size(), 0);

        // Triangle: empty HOLD and LOW
        set_a(5, 0, 5, 0, 3, 1);
        push_period(5, 0, 5, 0, 3, 65535, 1);
        start_pulse(0);
        run_ticks(0, 10);
        @(posedge clk);
        #1;
        chk("tri_idle", int'(busy_a), 0);

        // All segments empty
        set_a(0, 0, 0, 0, 7, 1);
        push_period(0, 0, 0, 0, 7, 65535, 1);
        start_pulse(0);
        run_ticks(0, 1);

        // Narrow instance saturation
        r_b = 10'd10; h_b = 10'd2; f_b = 10'd3; l_b = 10'd2; step_b = 8'd30; os_b = 1'b1;
        push_period(10, 2, 3, 2, 30, 255, 1);
        start_pulse(1);
        run_ticks(1, 17);
        chk("sb_drained_3", sb.size(), 0);

        // Abort by enable at tick 5 of HOLD
        set_a(20, 20, 20, 20, 1, 1);
        push_period(20, 20, 20, 20, 1, 65535, 1);
        start_pulse(0);
        run_ticks(0, 25);
        sb.delete();
        @(negedge clk);
        en_a = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ph", int'(ph_a), 0);
        chk("abort_sig", int'(sig_a), 0);
        chk("abort_busy", int'(busy_a), 0);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", int'(done_a), 0);
        end
        en_a = 1'b1;

        // Asynchronous reset during FALL
        push_period(20, 20, 20, 20, 1, 65535, 1);
        start_pulse(0);
        run_ticks(0, 45);
        sb.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_sig", int'(sig_a), 0);
        chk("midrst_ph", int'(ph_a), 0);
        chk("midrst_busy", int'(busy_a), 0);
        chk("midrst_done", int'(done_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            chk("postrst_wait", int'(busy_a) + int'(done_a), 0);
        end

        // Fresh start after reset works
        set_a(4, 1, 4, 1, 5, 1);
        push_period(4, 1, 4, 1, 5, 65535, 1);
        start_pulse(0);
        run_ticks(0, 10);
        chk("sb_drained_4", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
